// File: rtl/fft_frame_sequencer_if.sv
// Bundle between the frame sequencer and its neighbours: the sample stream,
// the fft_controller load/start/done port and the tagged result stream.
interface fft_frame_sequencer_if #(
  parameter int unsigned N = 64
);
  localparam int unsigned AW = $clog2(N);

  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;

  logic               fft_reset;
  logic               fft_load;
  logic [AW-1:0]      fft_load_address;
  logic [31:0]        fft_data_in;
  logic               fft_start;
  logic               fft_done;
  logic [31:0]        fft_data_out;

  logic               result_valid;
  logic [31:0]        result_data;
  logic [AW-1:0]      result_index;
  logic               frame_done;
  logic               error;

  modport master (
    input  sample_in, sample_valid, fft_done, fft_data_out,
    output sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in, fft_start,
           result_valid, result_data, result_index, frame_done, error
  );

  modport slave (
    output sample_in, sample_valid, fft_done, fft_data_out,
    input  sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in, fft_start,
           result_valid, result_data, result_index, frame_done, error
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Packs N samples into fft_controller RAM, starts the transform, waits for done
// and streams the N result words out with bin index tags, then re-arms.
module fft_frame_sequencer #(
  parameter int unsigned N           = 64,
  parameter int unsigned WORD_CYCLES = 4,
  parameter int unsigned OUT_LATENCY = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input logic                   clk,
  input logic                   reset_n,
  fft_frame_sequencer_if.master bus
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(2 * WORD_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = $clog2(OUT_LATENCY + 1);

  typedef enum logic [2:0] {StRst, StLoad, StStart, StWait, StDrain} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] w_q, w_d;
  logic [CW-1:0] r_q, r_d;
  logic [TW-1:0] t_q, t_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          seen_q, seen_d;
  logic          load_q, load_d;
  logic          gap_q, gap_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [AW-1:0] res_index_q, res_index_d;
  logic          frame_done_q, frame_done_d;
  logic          error_q, error_d;

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    w_d          = w_q;
    r_d          = r_q;
    t_d          = t_q;
    lat_d        = lat_q;
    seen_d       = seen_q;
    load_d       = load_q;
    gap_d        = gap_q;
    addr_d       = addr_q;
    din_d        = din_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_index_d  = res_index_q;
    frame_done_d = 1'b0;
    error_d      = error_q;

    unique case (state_q)
      StRst: begin
        if (p_q == PW'(2 * WORD_CYCLES - 1)) begin
          state_d = StLoad;
          p_d     = '0;
          w_d     = '0;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      StLoad: begin
        if (load_q) begin
          if (p_q == PW'(WORD_CYCLES - 1)) begin
            load_d = 1'b0;
            gap_d  = 1'b1;
            p_d    = '0;
          end else begin
            p_d = p_q + 1'b1;
          end
        end else if (gap_q) begin
          // One idle cycle with load low before the next word may be taken.
          gap_d = 1'b0;
          w_d   = w_q + 1'b1;
          if (w_q == CW'(N - 1)) begin
            state_d = StStart;
            p_d     = '0;
          end
        end else if (bus.sample_valid) begin
          load_d = 1'b1;
          p_d    = '0;
          addr_d = w_q[AW-1:0];
          din_d  = {bus.sample_in, 16'h0000};
        end
      end
      StStart: begin
        if (p_q == PW'(WORD_CYCLES - 1)) begin
          state_d = StWait;
          p_d     = '0;
          t_d     = '0;
          lat_d   = '0;
          seen_d  = 1'b0;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      StWait: begin
        if (seen_q || bus.fft_done) begin
          if (lat_q == LW'(OUT_LATENCY - 1)) begin
            state_d = StDrain;
            p_d     = '0;
            r_d     = '0;
          end else begin
            seen_d = 1'b1;
            lat_d  = lat_q + 1'b1;
          end
        end else if (t_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StRst;
          p_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (p_q == '0) begin
          res_valid_d  = 1'b1;
          res_data_d   = bus.fft_data_out;
          res_index_d  = r_q[AW-1:0];
          frame_done_d = (r_q == CW'(N - 1));
          r_d          = r_q + 1'b1;
        end
        // Finish the full slot of the last word so strobes stay evenly paced.
        if (p_q == PW'(WORD_CYCLES - 1)) begin
          p_d = '0;
          if (r_d == CW'(N)) begin
            state_d = StRst;
          end
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      default: begin
        state_d = StRst;
        p_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRst;
      p_q          <= '0;
      w_q          <= '0;
      r_q          <= '0;
      t_q          <= '0;
      lat_q        <= '0;
      seen_q       <= 1'b0;
      load_q       <= 1'b0;
      gap_q        <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_index_q  <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      w_q          <= w_d;
      r_q          <= r_d;
      t_q          <= t_d;
      lat_q        <= lat_d;
      seen_q       <= seen_d;
      load_q       <= load_d;
      gap_q        <= gap_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_index_q  <= res_index_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign bus.fft_reset        = (state_q == StRst);
  assign bus.sample_ready     = (state_q == StLoad) && !load_q && !gap_q;
  assign bus.fft_start        = (state_q == StStart);
  assign bus.fft_load         = load_q;
  assign bus.fft_load_address = addr_q;
  assign bus.fft_data_in      = din_q;
  assign bus.result_valid     = res_valid_q;
  assign bus.result_data      = res_data_q;
  assign bus.result_index     = res_index_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.error            = error_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomised bench for fft_frame_sequencer: a timeline model drives stimulus, plays
// the fft_controller and predicts every output, which one process compares each cycle.
module tb_fft_frame_sequencer;
  localparam int N   = 64;
  localparam int WC  = 4;
  localparam int LAT = 2;
  localparam int TO  = 4096;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.N(N)) bus ();

  fft_frame_sequencer #(
    .N           (N),
    .WORD_CYCLES (WC),
    .OUT_LATENCY (LAT),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks;
  int errors;

  // Expected outputs for the current cycle.
  logic        e_reset, e_ready, e_load, e_start, e_valid, e_fdone, e_error, e_zero;
  logic [5:0]  e_addr, e_ridx;
  logic [31:0] e_din, e_rdata;

  // Statistics over the directed first frame, pinned against literals.
  logic        mon = 1'b0;
  int          m_cyc = 0, m_ready_at = -1, m_rst = 0, m_start = 0, m_strobes = 0, m_fdone = 0;
  logic [31:0] m_last = '0, m_din5 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ctrl{reset,ready,load,start,valid,fdone,error}",
        {bus.fft_reset, bus.sample_ready, bus.fft_load, bus.fft_start,
         bus.result_valid, bus.frame_done, bus.error},
        {e_reset, e_ready, e_load, e_start, e_valid, e_fdone, e_error});
    if (e_load || e_zero) begin
      chk("fft_load_address", bus.fft_load_address, e_addr);
      chk("fft_data_in", bus.fft_data_in, e_din);
    end
    if (e_valid || e_zero) begin
      chk("result_index", bus.result_index, e_ridx);
      chk("result_data", bus.result_data, e_rdata);
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      m_cyc <= m_cyc + 1;
      if (bus.sample_ready && m_ready_at < 0) m_ready_at <= m_cyc + 1;
      if (bus.fft_reset && reset_n) m_rst <= m_rst + 1;
      if (bus.fft_start) m_start <= m_start + 1;
      if (bus.result_valid) begin
        m_strobes <= m_strobes + 1;
        m_last    <= bus.result_data;
      end
      if (bus.frame_done) m_fdone <= m_fdone + 1;
      if (bus.fft_load && bus.fft_load_address == 6'd5) m_din5 <= bus.fft_data_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_reset = 1'b0; e_ready = 1'b0; e_load = 1'b0; e_start = 1'b0;
    e_valid = 1'b0; e_fdone = 1'b0; e_zero = 1'b0;
  endtask

  task automatic junk_in();
    bus.sample_valid = 1'($urandom_range(0, 1));
    bus.sample_in    = 16'($urandom);
    bus.fft_done     = 1'b0;
    bus.fft_data_out = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    e_error = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      idle_exp();
      e_reset = 1'b1; e_zero = 1'b1;
      e_addr = '0; e_din = '0; e_ridx = '0; e_rdata = '0;
      junk_in();
      tick();
    end
    reset_n = 1'b1;
  endtask

  task automatic rst_phase();
    for (int i = 0; i < 2 * WC; i++) begin
      idle_exp();
      e_reset = 1'b1;
      junk_in();
      tick();
    end
  endtask

  // One frame: load N words, start, then either time out or play the controller.
  task automatic frame(input bit directed, input int dd, input bit tmo, input int abort_idx);
    logic [15:0] s;
    logic [31:0] words [N];
    int          drop_k;
    bit          offer;
    for (int k = 0; k < N; k++) words[k] = directed ? 32'hA000_0000 + 32'(k) : $urandom;
    for (int k = 0; k < N; k++) begin
      for (int tries = 0; tries < 16; tries++) begin
        idle_exp();
        e_ready = 1'b1;
        junk_in();
        offer = directed || tries >= 8 || ($urandom_range(0, 2) != 0);
        s = directed ? 16'(k + 1) : 16'($urandom);
        bus.sample_valid = offer;
        bus.sample_in    = s;
        tick();
        if (offer) break;
      end
      for (int i = 0; i < WC; i++) begin
        idle_exp();
        e_load = 1'b1; e_addr = 6'(k); e_din = {s, 16'h0000};
        junk_in();
        tick();
      end
      idle_exp();
      junk_in();
      tick();
    end
    for (int i = 0; i < WC; i++) begin
      idle_exp();
      e_start = 1'b1;
      junk_in();
      tick();
    end
    if (tmo) begin
      for (int c = 0; c < TO; c++) begin
        idle_exp();
        junk_in();
        tick();
      end
      e_error = 1'b1;
      return;
    end
    drop_k = directed ? N + 1 : $urandom_range(1, N + 1);
    for (int c = 0; c < dd + LAT + N * WC; c++) begin
      int wk;
      int j;
      idle_exp();
      junk_in();
      if (c >= dd) begin
        wk = (c - dd) / WC;
        if (wk < N) bus.fft_data_out = words[wk];
        bus.fft_done = (wk < drop_k);
      end
      j = c - dd - LAT;
      if (abort_idx >= 0 && j == WC * abort_idx + 3) begin
        do_reset(2);
        return;
      end
      if (j >= 0 && j % WC == 1) begin
        e_valid = 1'b1;
        e_ridx  = 6'((j - 1) / WC);
        e_rdata = words[(j - 1) / WC];
        e_fdone = ((j - 1) / WC == N - 1);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e_error = 1'b0;
    idle_exp();
    e_addr = '0; e_din = '0; e_ridx = '0; e_rdata = '0;
    junk_in();
    do_reset(3);

    mon = 1'b1;
    rst_phase();
    frame(1'b1, 800, 1'b0, -1);
    mon = 1'b0;
    chk("lit_reset_cycles", 64'(m_rst), 64'd8);
    chk("lit_ready_cycle", 64'(m_ready_at), 64'd9);
    chk("lit_start_cycles", 64'(m_start), 64'd4);
    chk("lit_strobes", 64'(m_strobes), 64'd64);
    chk("lit_frame_done", 64'(m_fdone), 64'd1);
    chk("lit_last_word", 64'(m_last), 64'hA000_003F);
    chk("lit_din_addr5", 64'(m_din5), 64'h0006_0000);

    rst_phase();
    frame(1'b0, $urandom_range(0, 1000), 1'b0, -1);
    rst_phase();
    frame(1'b0, 0, 1'b1, -1);
    rst_phase();
    frame(1'b0, $urandom_range(0, 300), 1'b0, -1);
    rst_phase();
    frame(1'b0, $urandom_range(0, 300), 1'b0, 20);
    rst_phase();
    frame(1'b0, 0, 1'b0, -1);
    rst_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Host-side master for fft_controller: accepts a stream of signed 16-bit audio samples and packs each 64-sample frame into fft_controller RAM 0 through its load port.
- Pulses start, waits for done, then captures the 64 streamed result words and presents them downstream with index tags.
- Re-arms automatically for the next frame.
- Sits between the sample front end and the spectral/harmonizer logic.

Parameters:
- N, 64, samples per frame; equals fft_controller depth; power of 2.
- WORD_CYCLES, 4, clk cycles per fft_controller slow_clk period; paces load holds, start pulse, and result capture.
- OUT_LATENCY, 2, clk cycles from first done-high observation to the first valid data_out sample point.
- TIMEOUT, 4096, maximum clk cycles in WAIT before error.

Ports:
- clk  in  1  system clock, same clk that drives fft_controller.
- reset_n  in  1  asynchronous active-low reset.
- sample_in  in  16  signed PCM sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  sequencer accepts sample this cycle.
- fft_reset  out  1  to fft_controller reset.
- fft_load  out  1  to fft_controller load.
- fft_load_address  out  6  to fft_controller load_address.
- fft_data_in  out  32  to fft_controller data_in; {real[15:0], imag[15:0]}.
- fft_start  out  1  to fft_controller start.
- fft_done  in  1  from fft_controller done.
- fft_data_out  in  32  from fft_controller data_out.
- result_valid  out  1  one-cycle strobe, result_data valid.
- result_data  out  32  captured FFT word {real, imag}.
- result_index  out  6  bin index of result_data, 0..N-1.
- frame_done  out  1  one-cycle strobe with the last bin (index N-1).
- error  out  1  sticky WAIT timeout flag; cleared only by reset_n.

Behaviour:
- Reset (async, reset_n=0): state=RST.
  - fft_reset=1; fft_load=0; fft_start=0; sample_ready=0; result_valid=0; frame_done=0; error=0.
  - All counters 0; fft_load_address=0; fft_data_in=0; result_data=0; result_index=0.
- States: RST, LOAD, START, WAIT, DRAIN.
- RST:
  - fft_reset=1 for 2*WORD_CYCLES clk cycles so slow_clk samples it at least once.
  - Then go to LOAD with word counter w=0.
- LOAD:
  - sample_ready=1 only while no word is being held.
  - On sample_valid&&sample_ready: fft_data_in={sample_in,16'h0000}, fft_load_address=w, fft_load=1.
  - Hold address, data and load for exactly WORD_CYCLES clk cycles; sample_ready=0 during the hold.
  - After the hold: fft_load=0 for one cycle, then w increments.
  - After word N-1 completes, go to START.
  - sample_valid low stalls indefinitely with no outputs asserted.
- START:
  - fft_start=1 for exactly WORD_CYCLES cycles, so it covers one slow_clk edge.
  - Then go to WAIT with timeout counter cleared.
- WAIT:
  - Count clk cycles.
  - On fft_done=1: wait OUT_LATENCY cycles, then go to DRAIN with capture counter r=0 and phase counter p=0.
  - If the counter reaches TIMEOUT first: error=1, go to RST (frame dropped).
- DRAIN:
  - p counts 0..WORD_CYCLES-1.
  - At p=0: result_data<=fft_data_out, result_index<=r, result_valid=1 for one cycle, r++.
  - frame_done=1 in the same cycle as index N-1.
  - After N captures, go to RST, which resets fft_controller counters and out_address for the next frame.
  - fft_done falling before N captures: capture continues to N anyway; no error.
- No backpressure on results: consumer must accept every strobe. Strobes are spaced exactly WORD_CYCLES apart.
- sample_ready=0 in RST, START, WAIT and DRAIN. Samples are not buffered; the upstream source must hold or drop them.
- fft_start and fft_load are never high in the same cycle. fft_reset is high only in RST.
- Width rules:
  - Counters w and r are log2(N)+1 bits so N is detectable.
  - fft_load_address and result_index carry the low 6 bits.
- reset_n mid-frame: immediate return to RST; the partial frame is discarded; no result_valid or frame_done follows.

Test Plan:
- Reset: reset_n low 3 cycles, then high -> fft_reset=1 for 8 cycles; sample_ready rises on cycle 9; all other outputs 0.
- Load pacing: feed 64 samples 0x0001..0x0040 back-to-back -> each fft_load_address k held 4 cycles with fft_data_in={k+1,16'h0}. Then fft_start high exactly 4 cycles. sample_ready never high during a hold.
- Drain: a controller model raises fft_done after 800 cycles and streams words 0xA000_0000+k every 4 cycles -> 64 result_valid strobes 4 cycles apart, indices 0..63, data matching; frame_done coincides with index 63.
- Back-to-back frames: two frames of samples -> second frame loads after RST; result_index restarts at 0; fft_reset pulse precedes the second load.
- Timeout: fft_done held 0 -> error=1 at cycle 4096 of WAIT; block returns to RST and accepts a new frame; error stays 1.
- Mid-operation reset: reset_n low during DRAIN at index 20 -> outputs cleared immediately; no further result_valid; no frame_done.
